// File: rtl/fft_io_sched_pkg.sv
// Shared definitions for the FFT host-side I/O sequencer: default geometry,
// RAM read latency, the sequencer state encoding and a bank-select helper.
package fft_io_sched_pkg;

  localparam int DEF_N_POINT = 2048;
  localparam int DEF_A_BIT   = 9;
  localparam int DEF_D_BIT   = 16;
  localparam int DEF_O_BIT   = 17;
  localparam int DEF_RD_LAT  = 1;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FETCH = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  // One-hot write enable for the bank that owns a given sample index
  function automatic logic [3:0] bankWe(input logic [1:0] bank);
    bankWe = 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/fft_io_serializer.sv
// Output side of the sequencer: holds the four bank words read for one
// address and presents them one by one on a valid/ready stream, bank 0 first.
module fft_io_serializer
  import fft_io_sched_pkg::*;
#(
  parameter int O_BIT = DEF_O_BIT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iCLR,
  input  logic             iLOAD,
  input  logic             iLAST_ADDR,
  input  logic [O_BIT-1:0] iHOLD_0,
  input  logic [O_BIT-1:0] iHOLD_1,
  input  logic [O_BIT-1:0] iHOLD_2,
  input  logic [O_BIT-1:0] iHOLD_3,
  input  logic             iM_READY,
  output logic [O_BIT-1:0] oM_DATA,
  output logic             oM_VALID,
  output logic             oM_LAST,
  output logic             oDONE
);

  logic [O_BIT-1:0] r_hold [4];
  logic [1:0]       r_sel;
  logic             r_valid;
  logic             r_last;
  logic [O_BIT-1:0] r_data;

  logic             w_fire;
  logic [1:0]       w_nextSel;

  assign w_fire    = r_valid && iM_READY;
  assign w_nextSel = r_sel + 2'd1;

  // Done means the fourth word of this address has just been accepted
  assign oDONE    = w_fire && (r_sel == 2'd3);
  assign oM_DATA  = r_data;
  assign oM_VALID = r_valid;
  assign oM_LAST  = r_last;

  // Capture a fresh address worth of data, then step through it per handshake
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < 4; i++) r_hold[i] <= '0;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (iCLR) begin
      for (int i = 0; i < 4; i++) r_hold[i] <= '0;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
    end else if (iLOAD) begin
      r_hold[0] <= iHOLD_0;
      r_hold[1] <= iHOLD_1;
      r_hold[2] <= iHOLD_2;
      r_hold[3] <= iHOLD_3;
      r_data    <= iHOLD_0;
      r_sel     <= 2'd0;
      r_valid   <= 1'b1;
      r_last    <= 1'b0;
    end else if (w_fire) begin
      if (r_sel == 2'd3) begin
        r_sel   <= 2'd0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_sel  <= w_nextSel;
        r_data <= r_hold[w_nextSel];
        r_last <= iLAST_ADDR && (r_sel == 2'd2);
      end
    end
  end

endmodule

// File: rtl/fft_io_sched.sv
// Host-side sequencer for the 4-bank radix-4 FFT core: scatters an input
// sample stream over the four banks, starts the core, waits for completion
// and streams the four result banks back out in memory order.
module fft_io_sched
  import fft_io_sched_pkg::*;
#(
  parameter int N_POINT = DEF_N_POINT,
  parameter int A_BIT   = DEF_A_BIT,
  parameter int D_BIT   = DEF_D_BIT,
  parameter int O_BIT   = DEF_O_BIT,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iCLR,
  input  logic [D_BIT-1:0] iS_DATA,
  input  logic             iS_VALID,
  output logic             oS_READY,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_RD,
  output logic             oSTART,
  input  logic             iFFT_RDY,
  input  logic [O_BIT-1:0] iDATA_RE_0,
  input  logic [O_BIT-1:0] iDATA_RE_1,
  input  logic [O_BIT-1:0] iDATA_RE_2,
  input  logic [O_BIT-1:0] iDATA_RE_3,
  output logic [O_BIT-1:0] oM_DATA,
  output logic             oM_VALID,
  input  logic             iM_READY,
  output logic             oM_LAST,
  output logic             oBUSY
);

  localparam int IN_W  = A_BIT + 2;
  localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  localparam logic [A_BIT-1:0] LAST_ADDR   = A_BIT'(N_POINT / 4 - 1);
  localparam logic [IN_W-1:0]  LAST_SAMPLE = IN_W'(N_POINT - 1);
  localparam logic [LAT_W-1:0] LAT_END     = LAT_W'(RD_LAT);

  state_t           r_state;
  state_t           w_next;

  logic             r_sReady;
  logic             r_busy;
  logic             r_start;
  logic [D_BIT-1:0] r_data;
  logic [3:0]       r_we;
  logic [A_BIT-1:0] r_addrWr;
  logic [IN_W-1:0]  r_inCnt;
  logic [A_BIT-1:0] r_addrRd;
  logic [LAT_W-1:0] r_lat;
  logic             r_rdyQ;
  logic             r_rdyPrev;

  logic             w_accept;
  logic             w_lastSample;
  logic             w_rdyRise;
  logic             w_capture;
  logic             w_done;
  logic             w_lastAddr;

  assign w_accept     = iS_VALID && r_sReady && (r_state == ST_LOAD);
  assign w_lastSample = w_accept && (r_inCnt == LAST_SAMPLE);
  assign w_rdyRise    = r_rdyQ && !r_rdyPrev;
  assign w_capture    = (r_state == ST_FETCH) && (r_lat == LAT_END);
  assign w_lastAddr   = (r_addrRd == LAST_ADDR);

  assign oS_READY = r_sReady;
  assign oBUSY    = r_busy;
  assign oSTART   = r_start;
  assign oDATA    = r_data;
  assign oWE      = r_we;
  assign oADDR_WR = r_addrWr;
  assign oADDR_RD = r_addrRd;

  // Next-state decision; abort overrides everything and returns to LOAD
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD:  if (w_lastSample) w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (w_rdyRise) w_next = ST_FETCH;
      ST_FETCH: if (w_capture) w_next = ST_EMIT;
      ST_EMIT:  if (w_done) w_next = w_lastAddr ? ST_LOAD : ST_FETCH;
      default:  w_next = ST_LOAD;
    endcase
    if (iCLR) w_next = ST_LOAD;
  end

  // State register
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) r_state <= ST_LOAD;
    else         r_state <= w_next;
  end

  // Status outputs follow the upcoming state so they are registered yet timely
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_sReady <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_sReady <= (w_next == ST_LOAD);
      r_busy   <= (w_next != ST_LOAD);
      r_start  <= (r_state == ST_START) && !iCLR;
    end
  end

  // Scatter accepted samples round-robin across the banks, one write per sample
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_inCnt  <= '0;
      r_data   <= '0;
      r_we     <= 4'b0000;
      r_addrWr <= '0;
    end else if (iCLR) begin
      r_inCnt  <= '0;
      r_data   <= '0;
      r_we     <= 4'b0000;
      r_addrWr <= '0;
    end else if (w_accept) begin
      r_data   <= iS_DATA;
      r_we     <= bankWe(r_inCnt[1:0]);
      r_addrWr <= r_inCnt[IN_W-1:2];
      r_inCnt  <= r_inCnt + IN_W'(1);
    end else begin
      r_we     <= 4'b0000;
    end
  end

  // Read address and RAM latency counter for the readout phase
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_addrRd <= '0;
      r_lat    <= '0;
    end else if (iCLR) begin
      r_addrRd <= '0;
      r_lat    <= '0;
    end else begin
      case (r_state)
        ST_FETCH: r_lat <= w_capture ? '0 : r_lat + LAT_W'(1);
        ST_EMIT: begin
          if (w_done) r_addrRd <= w_lastAddr ? '0 : r_addrRd + A_BIT'(1);
        end
        default: r_lat <= '0;
      endcase
    end
  end

  // Register the core completion flag and keep its previous value for edge detect
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_rdyQ    <= 1'b0;
      r_rdyPrev <= 1'b0;
    end else begin
      r_rdyQ    <= iFFT_RDY;
      r_rdyPrev <= r_rdyQ;
    end
  end

  fft_io_serializer #(
    .O_BIT(O_BIT)
  ) uSerializer (
    .iCLK      (iCLK),
    .iRESET    (iRESET),
    .iCLR      (iCLR),
    .iLOAD     (w_capture),
    .iLAST_ADDR(w_lastAddr),
    .iHOLD_0   (iDATA_RE_0),
    .iHOLD_1   (iDATA_RE_1),
    .iHOLD_2   (iDATA_RE_2),
    .iHOLD_3   (iDATA_RE_3),
    .iM_READY  (iM_READY),
    .oM_DATA   (oM_DATA),
    .oM_VALID  (oM_VALID),
    .oM_LAST   (oM_LAST),
    .oDONE     (w_done)
  );

endmodule

// File: tb/tb_fft_io_sched.sv
// Scoreboard bench for fft_io_sched: random samples and random output
// back-pressure, a bank model returning {tag, address, bank} and a monitor
// that compares every bank write and every result word against queues.
module tb_fft_io_sched;
  import fft_io_sched_pkg::*;

  localparam int N_POINT  = DEF_N_POINT;
  localparam int A_BIT    = DEF_A_BIT;
  localparam int D_BIT    = DEF_D_BIT;
  localparam int O_BIT    = DEF_O_BIT;
  localparam int RD_LAT   = DEF_RD_LAT;
  localparam int TAG_W    = O_BIT - A_BIT - 2;
  localparam int MAX_WAIT = 30000;

  logic             iCLK = 1'b0;
  logic             iRESET = 1'b0;
  logic             iCLR = 1'b0;
  logic [D_BIT-1:0] iS_DATA = '0;
  logic             iS_VALID = 1'b0;
  logic             oS_READY;
  logic [D_BIT-1:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic [3:0]       oWE;
  logic [A_BIT-1:0] oADDR_RD;
  logic             oSTART;
  logic             iFFT_RDY = 1'b0;
  logic [O_BIT-1:0] iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3;
  logic [O_BIT-1:0] oM_DATA;
  logic             oM_VALID;
  logic             iM_READY = 1'b1;
  logic             oM_LAST;
  logic             oBUSY;

  always #5 iCLK = ~iCLK;

  fft_io_sched dut (
    .iCLK(iCLK), .iRESET(iRESET), .iCLR(iCLR),
    .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oADDR_RD(oADDR_RD),
    .oSTART(oSTART), .iFFT_RDY(iFFT_RDY),
    .iDATA_RE_0(iDATA_RE_0), .iDATA_RE_1(iDATA_RE_1),
    .iDATA_RE_2(iDATA_RE_2), .iDATA_RE_3(iDATA_RE_3),
    .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .iM_READY(iM_READY),
    .oM_LAST(oM_LAST), .oBUSY(oBUSY)
  );

  // Result RAM model: word at address r of bank b reads back as {tag, r, b}
  logic [TAG_W-1:0] frameTag = '0;
  logic [A_BIT-1:0] bankPipe [1:RD_LAT];

  always @(posedge iCLK) begin
    bankPipe[1] <= oADDR_RD;
    for (int i = 2; i <= RD_LAT; i++) bankPipe[i] <= bankPipe[i-1];
  end

  assign iDATA_RE_0 = {frameTag, bankPipe[RD_LAT], 2'd0};
  assign iDATA_RE_1 = {frameTag, bankPipe[RD_LAT], 2'd1};
  assign iDATA_RE_2 = {frameTag, bankPipe[RD_LAT], 2'd2};
  assign iDATA_RE_3 = {frameTag, bankPipe[RD_LAT], 2'd3};

  typedef struct {
    logic [D_BIT-1:0] data;
    int               idx;
  } wrExp_t;

  typedef struct {
    logic [O_BIT-1:0] data;
    logic             last;
  } outExp_t;

  wrExp_t           wrQ[$];
  outExp_t          outQ[$];
  int               nChecks = 0;
  int               nFails = 0;
  int               acceptIdx = 0;
  int               emitted = 0;
  int               startCount = 0;
  bit               expectStart = 0;
  bit               prevStall = 0;
  logic [O_BIT-1:0] prevData = '0;
  logic             prevLast = 1'b0;
  bit               randReady = 0;
  bit               rdyNoise = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic failEvent(input string name, input string act, input string req);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: actual %s, required %s", name, act, req);
  endtask

  // Monitor: compares bank writes, the start pulse and result words to the queues
  always @(negedge iCLK) begin
    if (iRESET) begin
      if (expectStart) begin
        checkOutput("start_pulse", 32'(oSTART), 32'd1);
        expectStart = 0;
      end else if (oSTART) begin
        failEvent("spurious_start", "oSTART=1", "oSTART=0");
      end
      if (oSTART) startCount++;

      if (oWE != 4'b0000) begin
        if (wrQ.size() == 0) begin
          failEvent("unexpected_write", $sformatf("oWE=%b", oWE), "no write");
        end else begin
          wrExp_t e;
          e = wrQ.pop_front();
          checkOutput("wr_data", 32'(oDATA), 32'(e.data));
          checkOutput("wr_we", 32'(oWE), 32'(1 << (e.idx % 4)));
          checkOutput("wr_addr", 32'(oADDR_WR), 32'(e.idx / 4));
          if (e.idx == N_POINT - 1) expectStart = 1;
        end
      end

      if (prevStall) begin
        if (oM_VALID) begin
          checkOutput("stall_data", 32'(oM_DATA), 32'(prevData));
          checkOutput("stall_last", 32'(oM_LAST), 32'(prevLast));
        end else begin
          failEvent("stall_valid", "oM_VALID=0", "oM_VALID=1");
        end
      end
      prevStall = oM_VALID && !iM_READY;
      prevData  = oM_DATA;
      prevLast  = oM_LAST;

      if (oM_VALID && iM_READY) begin
        if (outQ.size() == 0) begin
          failEvent("unexpected_word", $sformatf("0x%0h", oM_DATA), "no word");
        end else begin
          outExp_t o;
          o = outQ.pop_front();
          checkOutput("out_data", 32'(oM_DATA), 32'(o.data));
          checkOutput("out_last", 32'(oM_LAST), 32'(o.last));
          emitted++;
        end
      end

      if (iS_VALID && oS_READY && !iCLR) begin
        wrQ.push_back('{iS_DATA, acceptIdx});
        acceptIdx = (acceptIdx + 1) % N_POINT;
      end
    end
  end

  // Downstream back-pressure and optional completion-flag noise
  initial begin
    forever begin
      @(posedge iCLK);
      #1;
      iM_READY = randReady ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rdyNoise) iFFT_RDY = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic toDrive();
    @(posedge iCLK);
    #1;
  endtask

  task automatic flushModel();
    wrQ.delete();
    outQ.delete();
    acceptIdx   = 0;
    expectStart = 0;
    prevStall   = 0;
  endtask

  // Offer one sample and hold it until the sequencer takes it
  task automatic applyStimulus(input logic [D_BIT-1:0] d);
    int guard;
    guard    = 0;
    iS_DATA  = d;
    iS_VALID = 1'b1;
    while (!oS_READY && guard < 1000) begin
      toDrive();
      guard++;
    end
    if (guard >= 1000) failEvent("accept_timeout", "never ready", "oS_READY=1");
    else toDrive();
    iS_VALID = 1'b0;
  endtask

  task automatic streamSamples(input int count);
    for (int i = 0; i < count; i++) applyStimulus(D_BIT'($urandom));
  endtask

  // Expected frame: word k of the frame is tag*N_POINT + k, last only on the final word
  task automatic pushFrameExpect();
    emitted = 0;
    for (int k = 0; k < N_POINT; k++)
      outQ.push_back('{O_BIT'(int'(frameTag) * N_POINT + k), (k == N_POINT - 1)});
  endtask

  initial begin
    int guard;

    // Reset state
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("rst_s_ready", 32'(oS_READY), 32'd0);
    checkOutput("rst_busy", 32'(oBUSY), 32'd0);
    checkOutput("rst_m_valid", 32'(oM_VALID), 32'd0);
    checkOutput("rst_we", 32'(oWE), 32'd0);
    checkOutput("rst_start", 32'(oSTART), 32'd0);
    checkOutput("rst_addr_rd", 32'(oADDR_RD), 32'd0);
    toDrive();
    iRESET = 1'b1;
    @(negedge iCLK);
    checkOutput("s_ready_before_edge", 32'(oS_READY), 32'd0);
    @(negedge iCLK);
    checkOutput("s_ready_after_release", 32'(oS_READY), 32'd1);

    // Reset in the middle of loading, then restart from bank 0 address 0
    toDrive();
    streamSamples(100);
    iRESET = 1'b0;
    flushModel();
    repeat (2) toDrive();
    iRESET = 1'b1;
    @(negedge iCLK);
    checkOutput("midload_rst_s_ready", 32'(oS_READY), 32'd0);
    @(negedge iCLK);
    checkOutput("midload_rst_s_ready_up", 32'(oS_READY), 32'd1);
    checkOutput("midload_rst_busy", 32'(oBUSY), 32'd0);

    // Frame 1: completion flag already high when WAIT is entered
    toDrive();
    iFFT_RDY = 1'b1;
    frameTag = TAG_W'($urandom);
    streamSamples(N_POINT);
    @(negedge iCLK);
    checkOutput("s_ready_after_frame", 32'(oS_READY), 32'd0);
    checkOutput("busy_after_frame", 32'(oBUSY), 32'd1);
    repeat (20) @(negedge iCLK);
    checkOutput("no_readout_on_level", 32'(oM_VALID), 32'd0);
    checkOutput("start_count_f1", 32'(startCount), 32'd1);
    toDrive();
    iFFT_RDY = 1'b0;
    repeat (3) toDrive();
    pushFrameExpect();
    randReady = 1;
    iFFT_RDY  = 1'b1;
    repeat (2 + RD_LAT) @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("fetch_addr_rd", 32'(oADDR_RD), 32'd0);
    checkOutput("fetch_no_valid_yet", 32'(oM_VALID), 32'd0);
    @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("capture_latency_valid", 32'(oM_VALID), 32'd1);
    rdyNoise = 1;
    guard = 0;
    while (outQ.size() != 0 && guard < MAX_WAIT) begin
      @(posedge iCLK);
      guard++;
    end
    if (guard >= MAX_WAIT) failEvent("drain_timeout", "words pending", "all words emitted");
    @(negedge iCLK);
    rdyNoise = 0;
    checkOutput("words_emitted_f1", 32'(emitted), 32'(N_POINT));
    checkOutput("drain_s_ready", 32'(oS_READY), 32'd1);
    checkOutput("drain_busy", 32'(oBUSY), 32'd0);
    checkOutput("drain_m_valid", 32'(oM_VALID), 32'd0);
    checkOutput("start_count_after_f1", 32'(startCount), 32'd1);

    // Frame 2: abort while waiting for the core
    toDrive();
    iFFT_RDY  = 1'b0;
    randReady = 0;
    streamSamples(N_POINT);
    repeat (5) toDrive();
    iCLR = 1'b1;
    toDrive();
    iCLR = 1'b0;
    flushModel();
    @(negedge iCLK);
    checkOutput("clr_wait_busy", 32'(oBUSY), 32'd0);
    checkOutput("clr_wait_m_valid", 32'(oM_VALID), 32'd0);
    checkOutput("clr_wait_s_ready", 32'(oS_READY), 32'd1);
    checkOutput("start_count_f2", 32'(startCount), 32'd2);

    // Frame 3: restart from index 0, then abort partway through the readout
    toDrive();
    streamSamples(N_POINT);
    frameTag = TAG_W'($urandom);
    pushFrameExpect();
    randReady = 1;
    repeat (4) toDrive();
    iFFT_RDY = 1'b1;
    guard = 0;
    while (emitted < 100 && guard < MAX_WAIT) begin
      @(posedge iCLK);
      guard++;
    end
    if (guard >= MAX_WAIT) failEvent("emit_timeout", "too few words", "100 words");
    #1;
    iCLR = 1'b1;
    toDrive();
    iCLR = 1'b0;
    iFFT_RDY = 1'b0;
    flushModel();
    @(negedge iCLK);
    checkOutput("clr_emit_m_valid", 32'(oM_VALID), 32'd0);
    checkOutput("clr_emit_m_last", 32'(oM_LAST), 32'd0);
    checkOutput("clr_emit_busy", 32'(oBUSY), 32'd0);
    checkOutput("clr_emit_addr_rd", 32'(oADDR_RD), 32'd0);
    checkOutput("start_count_f3", 32'(startCount), 32'd3);

    // After the abort the next sample must land in bank 0 at address 0
    toDrive();
    streamSamples(4);
    repeat (3) @(negedge iCLK);
    checkOutput("write_queue_drained", 32'(wrQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fft_io_sched.md
Name: fft_io_sched

Overview:
Host-side sequencer for the 4-bank radix-4 FFT core. Accepts a real-valued sample stream over a valid/ready handshake and scatters it into the core's four RAM banks. It then pulses the core's start input and waits for completion. Finally it reads the four real-part result banks back and serialises them onto a valid/ready output stream, with a last-word marker.

Parameters:
N_POINT, 2048, transform length; must be a multiple of 4
A_BIT, 9, bank address width; must equal log2(N_POINT/4)
D_BIT, 16, input sample width
O_BIT, 17, result word width
RD_LAT, 1, RAM read latency in cycles, from address to data valid

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous active-low reset
iCLR  in  1  synchronous abort; returns the block to LOAD with counters cleared
iS_DATA  in  D_BIT  input sample
iS_VALID  in  1  input sample valid
oS_READY  out  1  block accepts a sample this cycle
oDATA  out  D_BIT  sample to core (iDATA)
oADDR_WR  out  A_BIT  write address, common to all banks
oWE  out  4  one-hot bank write enable (iWE_0..3)
oADDR_RD  out  A_BIT  read address, common to all banks
oSTART  out  1  core start pulse
iFFT_RDY  in  1  core completion flag (core oRDY)
iDATA_RE_0..3  in  O_BIT each  bank read data
oM_DATA  out  O_BIT  result word
oM_VALID  out  1  result valid
iM_READY  in  1  downstream ready
oM_LAST  out  1  marks the final result word of a frame
oBUSY  out  1  high in every state except LOAD

Behaviour:
- States: LOAD, START, WAIT, FETCH, EMIT. Reset and iCLR force LOAD.
- All outputs are registered. Reset value of every output is 0, and all counters are 0.
- oS_READY rises on the first clock edge after reset release.
- iCLR takes priority over every other event and aborts any frame in progress. Input already accepted is discarded.
- LOAD:
  - oS_READY = 1. A sample is accepted when iS_VALID && oS_READY.
  - For accepted sample n (n = 0..N_POINT-1), on the next cycle: oDATA = sample, oWE = 1 << n[1:0], oADDR_WR = n >> 2, all for exactly one cycle.
  - After n = N_POINT-1 is accepted, oS_READY drops in the same edge and the state moves to START.
  - No bubble between consecutive accepts is required.
- START:
  - Entered on the cycle of the final write. oSTART = 1 on the following cycle, for exactly 1 cycle, so the final write lands before the core starts.
  - Then move to WAIT.
- WAIT:
  - Completion is a 0->1 transition of registered iFFT_RDY, detected while in WAIT. A level already high on entry is ignored.
  - On completion, go to FETCH with read address r = 0.
- FETCH:
  - oADDR_RD = r. After RD_LAT cycles, iDATA_RE_0..3 are captured into four hold registers.
  - Then go to EMIT with sel = 0.
- EMIT:
  - oM_VALID = 1 and oM_DATA = hold[sel]. oM_DATA is stable while iM_READY = 0.
  - On handshake, sel increments. Output order per address is bank 0,1,2,3, so word index k = 4r + sel, which is memory order, not digit-reversed.
  - After the sel = 3 handshake: if r = N_POINT/4-1, go to LOAD (oM_LAST was high with that word); otherwise r increments and the state returns to FETCH.
  - oM_VALID drops in the same edge as the final handshake of each address.
- oM_LAST = 1 only while emitting word N_POINT-1.
- Address counters are exact width and never wrap within a frame.
- A new frame's input is not accepted until the previous frame's output has fully drained. This prevents overwriting unread results.
- iFFT_RDY pulses in LOAD, START, FETCH or EMIT are ignored.

Decomposition:
- Shared package: state encoding, N_POINT/A_BIT/D_BIT/O_BIT defaults, and RD_LAT.
- One natural sub-module: fft_io_serializer, which holds the four hold registers, the sel counter, the output handshake and oM_LAST.

Test Plan:
- Reset mid-LOAD after 100 accepts, then release -> oS_READY = 1 one cycle later, and the next sample writes bank 0 at address 0 with oWE = 4'b0001.
- Stream samples 0..2047 back-to-back -> sample 4k+b is written with oWE bit b and oADDR_WR = k. Exactly one oSTART pulse appears, one cycle after the oWE for sample 2047. oS_READY = 0 from that point on.
- iFFT_RDY already high on WAIT entry -> no readout starts. Driving it low then high -> FETCH with oADDR_RD = 0, and capture happens RD_LAT cycles later.
- Bank model returning {r, b} per address -> 2048 words emitted in order 4r+b. oM_LAST appears only on word 2047, then the state returns to LOAD with oS_READY = 1.
- Random iM_READY (50%) during EMIT -> oM_DATA is held stable while stalled, with no loss or duplication across all 2048 words.
- iCLR asserted in WAIT and in EMIT -> next cycle is LOAD, all counters are 0, oM_VALID = 0 and oBUSY = 0.
